pc_ctrl_nway: RTL and testbench

PC_CTRL_NWAY -- requirements
Module: pc_ctrl_nway

---
 rtl/pc_ctrl_nway.sv | 170 +++++++++++++++++
 tb/tb_pc_ctrl_nway.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl_nway.sv
// N-lane fetch PC controller: lane PCs, redirect selection, next-PC and link values.
// Define PC_CTRL_RAS_EN to build the return-address stack used for JALR return prediction.
module pc_ctrl_nway #(
  parameter int XLEN = 32,
  parameter int LANES = 5,
  parameter int RAS_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  buble,
  input  logic                  parallel_mode,
  input  logic [LANES-1:0]      jump,
  input  logic [LANES-1:0]      jalr,
  input  logic [LANES-1:0]      call,
  input  logic [LANES-1:0]      ret,
  input  logic [LANES*XLEN-1:0] imm,
  input  logic                  misprediction,
  input  logic [XLEN-1:0]       correct_pc,
  output logic [LANES*XLEN-1:0] inst_addr,
  output logic [LANES*XLEN-1:0] current_pc,
  output logic [LANES*XLEN-1:0] pc_save,
  output logic [LANES-1:0]      lane_valid,
  output logic                  ras_empty,
  output logic                  ras_full
);

  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  next_pc_s;
  logic [XLEN-1:0]  fetch_base_s;
  logic [XLEN-1:0]  cur_pc_s [LANES];
  logic [XLEN-1:0]  offset_s [LANES];
  logic [LANES-1:0] lane_hit_s;
  logic             redirect_s;
  logic             blocked_s;
  logic             sel_jalr_s;
  logic             sel_call_s;
  logic             sel_ret_s;
  logic [XLEN-1:0]  sel_pc_s;
  logic [XLEN-1:0]  sel_offset_s;
  logic [XLEN-1:0]  link_s;
  logic [XLEN-1:0]  jalr_target_s;
  logic             unused_imm_s;

  assign lane_hit_s = jump | jalr;
  assign link_s     = sel_pc_s + XLEN'(4);

  // Per-lane PCs and offsets; walking down from the top lane leaves the lowest redirecting lane selected.
  always_comb begin
    redirect_s   = 1'b0;
    sel_jalr_s   = 1'b0;
    sel_call_s   = 1'b0;
    sel_ret_s    = 1'b0;
    sel_pc_s     = pc_r;
    sel_offset_s = '0;
    unused_imm_s = 1'b0;
    for (int k = LANES - 1; k >= 0; k--) begin
      cur_pc_s[k]  = parallel_mode ? pc_r + (XLEN'(k) << 2) : pc_r;
      offset_s[k]  = {imm[k*XLEN+2 +: XLEN-2], 2'b00};
      unused_imm_s = unused_imm_s ^ (^imm[k*XLEN +: 2]);
      redirect_s   = redirect_s | lane_hit_s[k];
      sel_jalr_s   = lane_hit_s[k] ? jalr[k]     : sel_jalr_s;
      sel_call_s   = lane_hit_s[k] ? call[k]     : sel_call_s;
      sel_ret_s    = lane_hit_s[k] ? ret[k]      : sel_ret_s;
      sel_pc_s     = lane_hit_s[k] ? cur_pc_s[k] : sel_pc_s;
      sel_offset_s = lane_hit_s[k] ? offset_s[k] : sel_offset_s;
    end
  end

  // Next-PC priority: execute redirect, stall, predecoded redirect, sequential.
  always_comb begin
    if (misprediction) begin
      next_pc_s = correct_pc;
    end else if (buble) begin
      next_pc_s = pc_r;
    end else if (redirect_s) begin
      next_pc_s = sel_jalr_s ? jalr_target_s : sel_pc_s + sel_offset_s;
    end else begin
      next_pc_s = pc_r + (parallel_mode ? (XLEN'(LANES) << 2) : XLEN'(4));
    end
  end

  assign fetch_base_s = reset ? RESET_PC : next_pc_s;

  // Lane outputs: lanes after the first redirect are squashed; single-issue keeps only lane 0.
  always_comb begin
    blocked_s = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      lane_valid[k] = parallel_mode ? ~blocked_s : (k == 32'sd0);
      blocked_s     = blocked_s | lane_hit_s[k];
      current_pc[k*XLEN +: XLEN] = cur_pc_s[k];
      pc_save[k*XLEN +: XLEN]    = lane_hit_s[k] ? cur_pc_s[k] + XLEN'(4)
                                                 : cur_pc_s[k] + offset_s[k];
      inst_addr[k*XLEN +: XLEN]  = parallel_mode ? fetch_base_s + (XLEN'(k) << 2) : fetch_base_s;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

`ifdef PC_CTRL_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem_r [RAS_DEPTH];
  logic [PW-1:0]   ras_top_r;
  logic [PW:0]     ras_cnt_r;
  logic            ras_empty_s;
  logic            ras_full_s;

  assign ras_empty_s   = (ras_cnt_r == (PW+1)'(0));
  assign ras_full_s    = (ras_cnt_r == (PW+1)'(RAS_DEPTH));
  assign ras_empty     = ras_empty_s;
  assign ras_full      = ras_full_s;
  assign jalr_target_s = (sel_ret_s && !ras_empty_s) ? ras_mem_r[ras_top_r] : link_s;

  // Circular return stack: a push when full overwrites the oldest entry, call+ret swaps the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_top_r <= '0;
      ras_cnt_r <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= '0;
      end
    end else if (misprediction) begin
      ras_cnt_r <= '0;
    end else if (!buble && redirect_s) begin
      case ({sel_call_s, sel_ret_s})
        2'b10: begin
          ras_top_r                      <= ras_top_r + PW'(1);
          ras_mem_r[ras_top_r + PW'(1)]  <= link_s;
          ras_cnt_r                      <= ras_full_s ? ras_cnt_r : ras_cnt_r + (PW+1)'(1);
        end
        2'b01: begin
          if (!ras_empty_s) begin
            ras_top_r <= ras_top_r - PW'(1);
            ras_cnt_r <= ras_cnt_r - (PW+1)'(1);
          end else begin
            ras_cnt_r <= ras_cnt_r;
          end
        end
        2'b11: begin
          ras_mem_r[ras_top_r] <= link_s;
        end
        default: begin
          ras_cnt_r <= ras_cnt_r;
        end
      endcase
    end else begin
      ras_cnt_r <= ras_cnt_r;
    end
  end

  logic unused_s;
  assign unused_s = unused_imm_s;
`else
  assign ras_empty     = 1'b1;
  assign ras_full      = 1'b0;
  assign jalr_target_s = link_s;

  logic unused_s;
  assign unused_s = unused_imm_s ^ sel_call_s ^ sel_ret_s;
`endif

endmodule

// File: tb/tb_pc_ctrl_nway.sv
// Directed bench for pc_ctrl_nway: queue-based reference model checked every cycle plus literal pins.
module tb_pc_ctrl_nway;

  localparam int LANES = 5;
  localparam int XLEN = 32;
  localparam int RAS_DEPTH = 8;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef PC_CTRL_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic clk;
  logic reset, buble, parallel_mode, misprediction;
  logic [LANES-1:0] jump, jalr, call, ret;
  logic [LANES*XLEN-1:0] imm;
  logic [31:0] correct_pc;
  logic [LANES*XLEN-1:0] inst_addr, current_pc, pc_save;
  logic [LANES-1:0] lane_valid;
  logic ras_empty, ras_full;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras [$];

  pc_ctrl_nway #(.XLEN(XLEN), .LANES(LANES), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .buble(buble), .parallel_mode(parallel_mode),
    .jump(jump), .jalr(jalr), .call(call), .ret(ret), .imm(imm),
    .misprediction(misprediction), .correct_pc(correct_pc),
    .inst_addr(inst_addr), .current_pc(current_pc), .pc_save(pc_save),
    .lane_valid(lane_valid), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lane_of(input logic [LANES*XLEN-1:0] v, input int k);
    return v[k*XLEN +: XLEN];
  endfunction

  task automatic chk(input string name, input int lane_i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane%0d: got 0x%08h expected 0x%08h", name, lane_i, act, exp);
    end
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    jump = '0; jalr = '0; call = '0; ret = '0; imm = '0;
    misprediction = 1'b0; buble = 1'b0;
  endtask

  // Reference model: PC plus return stack as a queue (newest at the back), checked each falling edge.
  initial begin : model_check
    logic [31:0] cur [LANES];
    logic [31:0] nxt, tgt, base;
    logic [LANES-1:0] exp_valid;
    int r;
    bit red;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_pc = RESET_PC;
        m_ras.delete();
      end
      red = 1'b0;
      r = 0;
      for (int k = 0; k < LANES; k++) cur[k] = parallel_mode ? m_pc + 32'(4*k) : m_pc;
      for (int k = LANES-1; k >= 0; k--) if (jump[k] || jalr[k]) begin red = 1'b1; r = k; end
      if (jalr[r]) begin
        if (RAS_EN && ret[r] && m_ras.size() > 0) tgt = m_ras[$];
        else tgt = cur[r] + 32'd4;
      end else begin
        tgt = cur[r] + (lane_of(imm, r) & 32'hFFFF_FFFC);
      end
      if (misprediction) nxt = correct_pc;
      else if (buble) nxt = m_pc;
      else if (red) nxt = tgt;
      else nxt = m_pc + (parallel_mode ? 32'(4*LANES) : 32'd4);
      base = reset ? RESET_PC : nxt;
      for (int k = 0; k < LANES; k++) begin
        exp_valid[k] = parallel_mode ? (!red || k <= r) : (k == 0);
        chk("inst_addr", k, lane_of(inst_addr, k), parallel_mode ? base + 32'(4*k) : base);
        chk("current_pc", k, lane_of(current_pc, k), cur[k]);
        chk("pc_save", k, lane_of(pc_save, k),
            (jump[k] || jalr[k]) ? cur[k] + 32'd4 : cur[k] + (lane_of(imm, k) & 32'hFFFF_FFFC));
      end
      chk("lane_valid", -1, 32'(lane_valid), 32'(exp_valid));
      chk("ras_empty", -1, 32'(ras_empty), RAS_EN ? 32'(m_ras.size() == 0) : 32'd1);
      chk("ras_full", -1, 32'(ras_full), RAS_EN ? 32'(m_ras.size() == RAS_DEPTH) : 32'd0);
      if (!reset) begin
        if (misprediction) begin
          m_ras.delete();
        end else if (!buble && red && RAS_EN) begin
          if (call[r] && ret[r]) begin
            if (m_ras.size() > 0) m_ras[m_ras.size()-1] = cur[r] + 32'd4;
          end else if (call[r]) begin
            if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
            m_ras.push_back(cur[r] + 32'd4);
          end else if (ret[r] && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
          end
        end
        m_pc = nxt;
      end
    end
  end

  initial begin
    reset = 1'b1; parallel_mode = 1'b1; correct_pc = 32'h0;
    clr();
    // Held in reset: lane 0 fetches RESET_PC, other lanes follow it.
    @(negedge clk);
    chk("rst_inst0", 0, lane_of(inst_addr, 0), 32'h0);
    chk("rst_inst1", 1, lane_of(inst_addr, 1), 32'h4);
    chk("rst_valid", -1, 32'(lane_valid), 32'h1F);
    chk("rst_empty", -1, 32'(ras_empty), 32'd1);
    chk("rst_full", -1, 32'(ras_full), 32'd0);
    adv(); reset = 1'b0;
    @(negedge clk); chk("seq_inst0_a", 0, lane_of(inst_addr, 0), 32'h14);
    adv();
    @(negedge clk); chk("seq_inst0_b", 0, lane_of(inst_addr, 0), 32'h28);
    adv(); misprediction = 1'b1; correct_pc = 32'h100;
    @(negedge clk); chk("mis_inst0", 0, lane_of(inst_addr, 0), 32'h100);
    // Two jumping lanes: the lower one wins.
    adv(); clr(); jump = 5'b10100; imm[2*32 +: 32] = 32'h40; imm[4*32 +: 32] = 32'h80;
    @(negedge clk);
    chk("jmp_inst0", 0, lane_of(inst_addr, 0), 32'h148);
    chk("jmp_valid", -1, 32'(lane_valid), 32'h07);
    chk("jmp_save2", 2, lane_of(pc_save, 2), 32'h10C);
    adv(); clr();
    @(negedge clk); chk("seq_inst0_c", 0, lane_of(inst_addr, 0), 32'h15C);
    adv(); jalr = 5'b01000;
    @(negedge clk);
    chk("jalr_inst0", 0, lane_of(inst_addr, 0), 32'h16C);
    chk("jalr_valid", -1, 32'(lane_valid), 32'h0F);
    adv(); clr(); parallel_mode = 1'b0;
    @(negedge clk);
    chk("si_inst4", 4, lane_of(inst_addr, 4), 32'h170);
    chk("si_valid", -1, 32'(lane_valid), 32'h01);
    adv(); jump = 5'b00001; imm[0 +: 32] = 32'hFFFF_FFFF;
    @(negedge clk); chk("si_back_jmp", 0, lane_of(inst_addr, 0), 32'h16C);
    // Call from lane 1 then return from lane 0.
    adv(); clr(); parallel_mode = 1'b1; misprediction = 1'b1; correct_pc = 32'h200;
    adv(); clr(); jump = 5'b00010; call = 5'b00010; imm[1*32 +: 32] = 32'h1000;
    @(negedge clk);
    chk("call_inst0", 0, lane_of(inst_addr, 0), 32'h1204);
    chk("call_empty_pre", -1, 32'(ras_empty), 32'd1);
    adv(); clr(); jalr = 5'b00001; ret = 5'b00001;
    @(negedge clk);
    chk("ret_empty_pre", -1, 32'(ras_empty), RAS_EN ? 32'd0 : 32'd1);
    chk("ret_inst0", 0, lane_of(inst_addr, 0), RAS_EN ? 32'h208 : 32'h1208);
    adv(); clr(); parallel_mode = 1'b0; misprediction = 1'b1; correct_pc = 32'h1000;
    @(negedge clk); chk("ret_empty_post", -1, 32'(ras_empty), 32'd1);
    // Nine pushes then nine pops, single-issue from lane 0.
    adv(); clr();
    for (int i = 0; i < 9; i++) begin
      jump = 5'b00001; call = 5'b00001; imm[0 +: 32] = 32'h100;
      @(negedge clk);
      chk("push_inst0", i, lane_of(inst_addr, 0), 32'h1100 + 32'(i*256));
      chk("push_full", i, 32'(ras_full), 32'(RAS_EN && i >= 8));
      adv();
    end
    clr();
    for (int j = 0; j < 9; j++) begin
      jalr = 5'b00001; ret = 5'b00001;
      @(negedge clk);
      chk("pop_inst0", j, lane_of(inst_addr, 0),
          RAS_EN ? ((j < 8) ? 32'h1804 - 32'(j*256) : 32'h1108) : 32'h1904 + 32'(j*4));
      chk("pop_empty", j, 32'(ras_empty), 32'(!RAS_EN || j == 8));
      adv();
    end
    clr(); parallel_mode = 1'b1; misprediction = 1'b1; correct_pc = 32'h400;
    @(negedge clk); chk("pop9_empty", -1, 32'(ras_empty), 32'd1);
    // Stall holds PC and stack; misprediction overrides the stall and flushes.
    adv(); clr(); jump = 5'b00001; call = 5'b00001; imm[0 +: 32] = 32'h20;
    @(negedge clk); chk("c2_inst0", 0, lane_of(inst_addr, 0), 32'h420);
    adv(); clr(); buble = 1'b1;
    @(negedge clk);
    chk("bub_inst0", 0, lane_of(inst_addr, 0), 32'h420);
    chk("bub_empty", -1, 32'(ras_empty), RAS_EN ? 32'd0 : 32'd1);
    adv(); misprediction = 1'b1; correct_pc = 32'h500;
    @(negedge clk);
    chk("bubmis_inst0", 0, lane_of(inst_addr, 0), 32'h500);
    chk("bubmis_cur0", 0, lane_of(current_pc, 0), 32'h420);
    adv(); clr();
    @(negedge clk);
    chk("flush_cur0", 0, lane_of(current_pc, 0), 32'h500);
    chk("flush_empty", -1, 32'(ras_empty), 32'd1);
    chk("flush_inst0", 0, lane_of(inst_addr, 0), 32'h514);
    adv(); misprediction = 1'b1; correct_pc = 32'h300;
    adv(); clr(); jalr = 5'b00001; ret = 5'b00001;
    @(negedge clk);
    chk("ret_empty_inst0", 0, lane_of(inst_addr, 0), 32'h304);
    chk("ret_empty_flag", -1, 32'(ras_empty), 32'd1);
    // Address wrap-around modulo 2^32.
    adv(); clr(); misprediction = 1'b1; correct_pc = 32'hFFFF_FFF8;
    adv(); clr();
    @(negedge clk);
    chk("wrap_cur4", 4, lane_of(current_pc, 4), 32'h8);
    chk("wrap_inst0", 0, lane_of(inst_addr, 0), 32'hC);
    // Asynchronous reset mid-cycle with a non-empty stack.
    adv(); jump = 5'b00001; call = 5'b00001; imm[0 +: 32] = 32'h40;
    adv(); clr();
    #2 reset = 1'b1;
    #1;
    chk("arst_cur0", 0, lane_of(current_pc, 0), 32'h0);
    chk("arst_inst0", 0, lane_of(inst_addr, 0), 32'h0);
    chk("arst_empty", -1, 32'(ras_empty), 32'd1);
    @(negedge clk);
    adv(); reset = 1'b0;
    @(negedge clk); chk("arst_rel_inst0", 0, lane_of(inst_addr, 0), 32'h14);
    adv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
